button_conditioner: RTL and testbench

- Front-end conditioner for the three raw front-panel push-buttons (mode, increase, decrease) of the clock/calendar top level.
- Synchronises and debounces each button, then emits clean single-cycle press pulses.
- Adds hold-to-auto-repeat on increase/decrease, so the time/date adjust counters and the mode FSM consume exactly one event per intended press.
- Sits directly between the board pins and the mode FSM and adjust counters.

---
 rtl/button_conditioner.sv | 180 ++++++++++++++++++
 tb/tb_button_conditioner.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Conditions the three raw front-panel buttons: two-flop sync, debounce,
// single-cycle press pulses, and hold-to-repeat on increase/decrease.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES     = 500000,
  parameter int REPEAT_DELAY_CYCLES = 25000000,
  parameter int REPEAT_RATE_CYCLES  = 5000000,
  parameter int CNT_W               = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic mode_button_n,
  input  logic increase_button_n,
  input  logic decrease_button_n,
  input  logic adjust_en,
  output logic mode_pulse,
  output logic increase_pulse,
  output logic decrease_pulse,
  output logic mode_db_n,
  output logic increase_db_n,
  output logic decrease_db_n
);

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rpt_state_e;

  // Bit 0 = mode, bit 1 = increase, bit 2 = decrease.
  logic [2:0] raw_n;
  logic [2:0] sync1_reg, sync2_reg;
  logic [2:0] db_reg, db_next, db_prev_reg;
  logic [2:0] press;
  logic [2:0] pulse_reg;
  logic [1:0] rpt_pulse;
  logic       lockout_reg, lockout_next;
  logic       lock_set, lock_clr, rpt_gate;

  assign raw_n = {decrease_button_n, increase_button_n, mode_button_n};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg   <= '1;
      sync2_reg   <= '1;
      db_reg      <= '1;
      db_prev_reg <= '1;
      pulse_reg   <= '0;
      lockout_reg <= 1'b0;
    end else begin
      sync1_reg   <= raw_n;
      sync2_reg   <= sync1_reg;
      db_reg      <= db_next;
      db_prev_reg <= db_reg;
      pulse_reg   <= {rpt_pulse, press[0]};
      lockout_reg <= lockout_next;
    end
  end

  assign press = db_prev_reg & ~db_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_debounce
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             level_next;

      // The timer only runs while the synchronised input disagrees with the
      // accepted level; any agreeing sample restarts the count.
      always_comb begin
        level_next = db_reg[gi];
        cnt_next   = '0;
        if (sync2_reg[gi] != db_reg[gi]) begin
          if (cnt_reg >= DB_LAST) begin
            level_next = sync2_reg[gi];
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_reg <= '0;
        else      cnt_reg <= cnt_next;
      end

      assign db_next[gi] = level_next;
    end
  endgenerate

  // Both adjust buttons down locks out repeats until both are released.
  assign lock_set = ~db_reg[1] & ~db_reg[2];
  assign lock_clr =  db_reg[1] &  db_reg[2];

  always_comb begin
    lockout_next = lockout_reg;
    if (lock_set)      lockout_next = 1'b1;
    else if (lock_clr) lockout_next = 1'b0;
  end

  assign rpt_gate = ~adjust_en | lockout_reg | lock_set;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_repeat
      rpt_state_e       state_reg, state_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic [CNT_W-1:0] cnt_inc;
      logic             pulse_next;

      assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pulse_next = 1'b0;
        if (rpt_gate) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          case (state_reg)
            ST_IDLE: begin
              cnt_next = '0;
              if (press[gi+1]) begin
                state_next = ST_DELAY;
                pulse_next = 1'b1;
              end
            end
            ST_DELAY: begin
              // Release is taken on the edge the debounced level returns high.
              if (db_next[gi+1]) begin
                state_next = ST_IDLE;
                cnt_next   = '0;
              end else if (cnt_reg >= DELAY_LAST) begin
                state_next = ST_REPEAT;
                cnt_next   = '0;
                pulse_next = 1'b1;
              end else begin
                cnt_next = cnt_inc;
              end
            end
            ST_REPEAT: begin
              if (db_next[gi+1]) begin
                state_next = ST_IDLE;
                cnt_next   = '0;
              end else if (cnt_reg >= RATE_LAST) begin
                cnt_next   = '0;
                pulse_next = 1'b1;
              end else begin
                cnt_next = cnt_inc;
              end
            end
            default: begin
              state_next = ST_IDLE;
              cnt_next   = '0;
            end
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      assign rpt_pulse[gi] = pulse_next;
    end
  endgenerate

  assign mode_pulse     = pulse_reg[0];
  assign increase_pulse = pulse_reg[1];
  assign decrease_pulse = pulse_reg[2];
  assign mode_db_n      = db_reg[0];
  assign increase_db_n  = db_reg[1];
  assign decrease_db_n  = db_reg[2];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with small timing parameters
// (debounce 4, repeat delay 20, repeat rate 5).
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mode_button_n = 1'b1;
  logic increase_button_n = 1'b1;
  logic decrease_button_n = 1'b1;
  logic adjust_en = 1'b1;
  logic mode_pulse, increase_pulse, decrease_pulse;
  logic mode_db_n, increase_db_n, decrease_db_n;

  int total = 0;
  int bad = 0;
  int mode_seen = 0;
  int inc_seen = 0;
  int dec_seen = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY_CYCLES(20),
    .REPEAT_RATE_CYCLES(5),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mode_button_n(mode_button_n),
    .increase_button_n(increase_button_n),
    .decrease_button_n(decrease_button_n),
    .adjust_en(adjust_en),
    .mode_pulse(mode_pulse),
    .increase_pulse(increase_pulse),
    .decrease_pulse(decrease_pulse),
    .mode_db_n(mode_db_n),
    .increase_db_n(increase_db_n),
    .decrease_db_n(decrease_db_n)
  );

  // Advance one clock edge and sample 1 time unit after it.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      mode_seen += int'(mode_pulse);
      inc_seen  += int'(increase_pulse);
      dec_seen  += int'(decrease_pulse);
    end
  endtask

  task automatic clear_seen();
    mode_seen = 0;
    inc_seen  = 0;
    dec_seen  = 0;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
    $display("check %s observed=%0b expected=%0b", tag, obs, exp);
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    logic exp_p;

    // Reset held with every button pressed.
    mode_button_n = 1'b0;
    increase_button_n = 1'b0;
    decrease_button_n = 1'b0;
    tick(5);
    chk("rst_mode_pulse", mode_pulse, 1'b0);
    chk("rst_inc_pulse", increase_pulse, 1'b0);
    chk("rst_dec_pulse", decrease_pulse, 1'b0);
    chk("rst_mode_db", mode_db_n, 1'b1);
    chk("rst_inc_db", increase_db_n, 1'b1);
    chk("rst_dec_db", decrease_db_n, 1'b1);
    rst = 1'b1;
    clear_seen();
    tick(6);
    chk("rst_rel_mode_e6", mode_pulse, 1'b0);
    chk("rst_rel_inc_db_e6", increase_db_n, 1'b0);
    tick(1);
    chk("rst_rel_mode_e7", mode_pulse, 1'b1);
    tick(20);
    chk_n("rst_rel_inc_cnt", inc_seen, 0);
    chk_n("rst_rel_dec_cnt", dec_seen, 0);
    chk_n("rst_rel_mode_cnt", mode_seen, 1);
    mode_button_n = 1'b1;
    increase_button_n = 1'b1;
    decrease_button_n = 1'b1;
    tick(10);

    // Single mode press.
    clear_seen();
    mode_button_n = 1'b0;
    tick(5);
    chk("single_db_e5", mode_db_n, 1'b1);
    tick(1);
    chk("single_db_e6", mode_db_n, 1'b0);
    chk("single_pulse_e6", mode_pulse, 1'b0);
    tick(1);
    chk("single_pulse_e7", mode_pulse, 1'b1);
    tick(1);
    chk("single_pulse_e8", mode_pulse, 1'b0);
    tick(22);
    chk_n("single_cnt", mode_seen, 1);
    mode_button_n = 1'b1;
    tick(15);
    chk("single_rel_db", mode_db_n, 1'b1);
    chk_n("single_rel_cnt", mode_seen, 1);

    // Bouncing increase, then steady low.
    clear_seen();
    for (int b = 0; b < 10; b++) begin
      increase_button_n = 1'b0;
      tick(3);
      increase_button_n = 1'b1;
      tick(1);
    end
    chk_n("bounce_cnt", inc_seen, 0);
    chk("bounce_db", increase_db_n, 1'b1);
    increase_button_n = 1'b0;
    tick(6);
    chk("bounce_e6", increase_pulse, 1'b0);
    tick(1);
    chk("bounce_e7", increase_pulse, 1'b1);

    // Auto-repeat: hold on from the press pulse just seen (edge P).
    clear_seen();
    for (int off = 1; off <= 70; off++) begin
      tick(1);
      exp_p = (off == 20) || (off >= 25 && off <= 55 && (off % 5) == 0);
      chk($sformatf("repeat_off%0d", off), increase_pulse, exp_p);
      if (off == 54) increase_button_n = 1'b1;
    end
    chk_n("repeat_cnt", inc_seen, 8);
    chk("repeat_rel_db", increase_db_n, 1'b1);
    tick(10);

    // Lockout between increase and decrease.
    clear_seen();
    decrease_button_n = 1'b0;
    tick(7);
    chk("lock_dec_press", decrease_pulse, 1'b1);
    tick(10);
    increase_button_n = 1'b0;
    tick(40);
    chk_n("lock_both_inc", inc_seen, 0);
    chk_n("lock_both_dec", dec_seen, 1);
    decrease_button_n = 1'b1;
    tick(40);
    chk_n("lock_half_inc", inc_seen, 0);
    chk_n("lock_half_dec", dec_seen, 1);
    increase_button_n = 1'b1;
    tick(10);
    decrease_button_n = 1'b0;
    tick(6);
    chk("lock_repress_e6", decrease_pulse, 1'b0);
    tick(1);
    chk("lock_repress_e7", decrease_pulse, 1'b1);
    decrease_button_n = 1'b1;
    tick(10);

    // Adjust disabled: inc/dec suppressed, mode unaffected.
    adjust_en = 1'b0;
    clear_seen();
    increase_button_n = 1'b0;
    tick(30);
    increase_button_n = 1'b1;
    tick(10);
    decrease_button_n = 1'b0;
    tick(30);
    decrease_button_n = 1'b1;
    tick(10);
    chk_n("noadj_inc_cnt", inc_seen, 0);
    chk_n("noadj_dec_cnt", dec_seen, 0);
    mode_button_n = 1'b0;
    tick(7);
    chk("noadj_mode_e7", mode_pulse, 1'b1);
    mode_button_n = 1'b1;
    tick(10);

    // Enable raised mid-hold: nothing until a fresh press.
    clear_seen();
    increase_button_n = 1'b0;
    tick(12);
    adjust_en = 1'b1;
    tick(40);
    chk_n("midhold_inc_cnt", inc_seen, 0);
    increase_button_n = 1'b1;
    tick(10);
    increase_button_n = 1'b0;
    tick(7);
    chk("midhold_repress_e7", increase_pulse, 1'b1);
    increase_button_n = 1'b1;
    tick(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
